// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Hazard and sequencing controller for the 16-bit five-stage MISC-V pipeline.
// It drives the write enables and flushes of the IF/ID, ID/EX, EX/MEM and
// MEM/WB pipeline registers and the PC write enable. It resolves load-use
// hazards, taken-branch flushes, memory wait states and a debug halt/drain
// request. Only control state lives here: the FSM, its counters and status bits.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When it is defined, saturating 16-bit stall/flush performance counters are
//   built. When it is undefined, stall_cnt and flush_cnt are tied to zero.
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   id_rs1/id_rs2            source indices of the instruction in ID
//   id_uses_rs1/id_uses_rs2  the ID instruction reads that source
//   ex_rd, ex_is_load        destination and load flag of the EX instruction
//   ex_branch_taken          EX resolved a taken branch or jump
//   mem_req, mem_ready       MEM access pending / completes this cycle
//   halt_req                 level request to drain and halt
//   pc_we .. mem_wb_we       register write enables
//   if_id_flush/id_ex_flush  load a NOP (zeros) when the matching we is also 1
//   halted                   pipeline drained and frozen
//   mem_err                  sticky memory-timeout flag
//   stall_cnt, flush_cnt     performance counters

module pipeline_ctrl #(
    parameter int REG_AW       = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              id_ex_we,
    output logic              ex_mem_we,
    output logic              mem_wb_we,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              halted,
    output logic              mem_err,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t        state_q, state_d;
    state_t        ret_q, ret_d;
    state_t        act_state;
    logic [DW-1:0] drain_q, drain_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          mem_err_q, mem_err_d;

    logic freeze;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    // Hazard detection. A load into x0 never creates a dependency.
    always_comb begin
        freeze   = mem_req & ~mem_ready;
        rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
        load_use = ex_is_load & (ex_rd != '0) & (rs1_hit | rs2_hit);
    end

    // Next state and enables. While waiting on memory, an unfrozen cycle
    // follows the rules of the state that was interrupted (act_state), so the
    // ready cycle already advances the pipeline and the FSM returns afterwards.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        drain_d     = drain_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        act_state   = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

        if (reset) begin
            state_d   = ST_RUN;
            ret_d     = ST_RUN;
            drain_d   = '0;
            wait_d    = '0;
            mem_err_d = 1'b0;
        end else if (state_q == ST_HALTED) begin
            // Frozen; memory stalls are irrelevant here.
            if (!halt_req) begin
                state_d = ST_RUN;
            end
        end else if (freeze) begin
            if (state_q == ST_MEM_WAIT) begin
                if (wait_q < WW'(MEM_TIMEOUT)) begin
                    wait_d = wait_q + WW'(1);
                end
                if (wait_q >= WW'(MEM_TIMEOUT - 1)) begin
                    mem_err_d = 1'b1;
                end
            end else begin
                state_d = ST_MEM_WAIT;
                ret_d   = state_q;
                wait_d  = '0;
            end
        end else begin
            state_d = act_state;

            if (ex_branch_taken) begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                id_ex_we    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
            end else begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
            end

            if (act_state == ST_RUN) begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end else begin
                // Draining: stop fetching and feed NOPs into IF/ID so the
                // instructions already in flight retire.
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
                pc_we       = ex_branch_taken;

                if (ex_branch_taken) begin
                    drain_d = '0;
                end else if (!load_use) begin
                    drain_d = drain_q + DW'(1);
                end

                if (!halt_req) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else if (!ex_branch_taken && !load_use &&
                             (drain_q == DW'(DRAIN_CYCLES - 1))) begin
                    state_d = ST_HALTED;
                end
            end
        end
    end

    // State register; reset is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        ret_q     <= ret_d;
        drain_q   <= drain_d;
        wait_q    <= wait_d;
        mem_err_q <= mem_err_d;
    end

    assign halted  = (state_q == ST_HALTED) & ~reset;
    assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        stall_ev;
    logic        flush_ev;

    // A stall is counted only when one is actually applied: a branch in the
    // same cycle overrides load-use, and a halted pipeline does not stall.
    always_comb begin
        stall_ev    = ~reset & (state_q != ST_HALTED) &
                      (freeze | (load_use & ~ex_branch_taken));
        flush_ev    = ~reset & (state_q != ST_HALTED) & ~freeze & ex_branch_taken;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_ev && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (flush_ev && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt = reset ? 16'd0 : stall_cnt_q;
    assign flush_cnt = reset ? 16'd0 : flush_cnt_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 16-bit five-stage MISC-V pipeline. Drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write-enable. Resolves load-use hazards, taken-branch flushes, memory wait states and a debug halt/drain request. Purely a control block: holds only its FSM, counters and status bits, no datapath values.

## Interface
- REG_AW, 4, register-index width of rs1/rs2/rd
- DRAIN_CYCLES, 4, advancing cycles needed to empty the pipeline before HALTED
- MEM_TIMEOUT, 64, MEM_WAIT cycles without mem_ready before mem_err sets
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  REG_AW  source indices of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads that source
- ex_rd  in  REG_AW  destination of the instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- mem_req, mem_ready  in  1  MEM-stage access pending / completes this cycle
- halt_req  in  1  level request to drain and halt
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1  register enables
- if_id_flush, id_ex_flush  out  1  when flush and the matching we are both 1, the register loads zeros (NOP)
- halted  out  1  pipeline drained and frozen
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt, flush_cnt  out  16  performance counters (see Configuration)

## Operation
- freeze = mem_req & ~mem_ready. load_use = ex_is_load & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority per cycle: reset > freeze > ex_branch_taken > load_use > normal.
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Enables and flushes are combinational from state and inputs.
- freeze (RUN/DRAIN/MEM_WAIT): all five we=0, flushes 0. From RUN or DRAIN, enter MEM_WAIT and record the return state; wait counter clears to 0.
- MEM_WAIT: wait counter increments each frozen cycle. On reaching MEM_TIMEOUT, mem_err=1 (sticky until reset) and waiting continues. In a cycle with mem_ready=1, the cycle is treated as normal in the return state, and the FSM returns to it the next cycle.
- Branch, unfrozen: all we=1, pc_we=1, if_id_flush=1, id_ex_flush=1.
- Load-use, unfrozen, no branch: pc_we=0, if_id_we=0, id_ex_we=1 with id_ex_flush=1 (bubble), ex_mem_we=mem_wb_we=1.
- Normal RUN: all we=1, no flush.
- RUN with halt_req=1 in an unfrozen cycle: go to DRAIN with drain counter=0.
- DRAIN: pc_we=0 (branch cycle: pc_we=1), if_id_we=1, if_id_flush=1. Other enables follow the branch/load-use rules.
  - Drain counter +1 per unfrozen, non-load-use cycle. A branch resets it to 0.
  - Counter reaching DRAIN_CYCLES → HALTED.
  - halt_req=0 → RUN next cycle, counter discarded.
- HALTED: all we=0, flushes 0, halted=1. halt_req=0 → RUN next cycle. freeze is ignored.
- Simultaneous halt_req and branch in RUN: branch actions apply and DRAIN is entered.

## Timing
- Reset (synchronous): state=RUN, all counters 0, mem_err=0, halted=0. While reset=1, all we=0, flushes=0, stall_cnt=flush_cnt=0.
- Zero-latency control: enables respond in the same cycle as the hazard inputs.
- Load-use costs exactly one bubble. ex_is_load is cleared by the bubble, so the stall releases on its own.
- halted rises the cycle after the DRAIN_CYCLES-th advancing DRAIN cycle. Minimum is halt_req + DRAIN_CYCLES+1 cycles.
- Reset asserted mid-MEM_WAIT or mid-DRAIN aborts immediately to RUN. No outstanding state survives.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cnt +1 each cycle with freeze or load_use; flush_cnt +1 each unfrozen branch cycle. Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Undefined: counters are not built; stall_cnt and flush_cnt are tied to 0.

## Test plan
- Normal flow: no hazards for 10 cycles → all five we=1 every cycle, flushes 0, halted=0.
- Load-use: ex_is_load=1, ex_rd=3, id_rs2=3, id_uses_rs2=1 → one cycle of pc_we=0, if_id_we=0, id_ex_flush=1. With ex_rd=0 → no stall.
- Branch + load-use same cycle: ex_branch_taken=1 with a load-use match → pc_we=1, both flushes=1, no stall. flush_cnt=1 with PERF_EN.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles then 1 → all we=0 for 5 cycles, all we=1 on the ready cycle. Hold 64 cycles with MEM_TIMEOUT=64 → mem_err=1 and stays set.
- Drain/halt: halt_req=1 in RUN, no hazards → halted=1 after 5 cycles, all we=0. Deassert → RUN next cycle. Deassert during DRAIN → RUN, halted never rises.
- Reset mid-MEM_WAIT: reset=1 for one cycle → next cycle state RUN, mem_err=0, stall_cnt=0.
